// File: rtl/execute_stage.sv
// Execute stage: D->E register, operand forwarding, ALU and a shift-add multiplier with HI/LO.
// Latency: one D->E register; stallE holds it, flushE bubbles it, hilo_stall asks for a hold while HI/LO is pending.
module execute_stage #(
  parameter int WIDTH   = 32,
  parameter int MUL_CYC = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallE,
  input  logic             flushE,
  input  logic             regwriteD,
  input  logic             memwriteD,
  input  logic             regdstD,
  input  logic             jumpD,
  input  logic             multstartD,
  input  logic             multsgnD,
  input  logic [3:0]       wbsrcD,
  input  logic [2:0]       alucontrolD,
  input  logic [1:0]       alusrcD,
  input  logic [WIDTH-1:0] rd1D,
  input  logic [WIDTH-1:0] rd2D,
  input  logic [WIDTH-1:0] signimmD,
  input  logic [WIDTH-1:0] unsignimmD,
  input  logic [WIDTH-1:0] pcplus4D,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       reD,
  input  logic [1:0]       forwardAE,
  input  logic [1:0]       forwardBE,
  input  logic [WIDTH-1:0] resultW,
  input  logic [WIDTH-1:0] aluoutM,
  output logic             regwriteE,
  output logic             memwriteE,
  output logic [3:0]       wbsrcE,
  output logic [4:0]       rsE,
  output logic [4:0]       rtE,
  output logic [4:0]       writeregE,
  output logic [WIDTH-1:0] aluoutE,
  output logic [WIDTH-1:0] writedataE,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mult_busy,
  output logic             hilo_stall
);

  localparam int CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
  localparam logic [3:0] WB_MFLO = 4'b1101;
  localparam logic [3:0] WB_MFHI = 4'b1011;
  localparam logic [3:0] WB_JAL  = 4'b0000;

  typedef struct packed {
    logic             regwrite;
    logic             memwrite;
    logic             regdst;
    logic             jump;
    logic             multstart;
    logic             multsgn;
    logic [3:0]       wbsrc;
    logic [2:0]       alucontrol;
    logic [1:0]       alusrc;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] signimm;
    logic [WIDTH-1:0] unsignimm;
    logic [WIDTH-1:0] pcplus4;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       re;
  } deReg_t;

  typedef enum logic {IDLE, RUN} mulState_t;

  deReg_t dIn, e;

  always_comb begin
    dIn            = '0;
    dIn.regwrite   = regwriteD;
    dIn.memwrite   = memwriteD;
    dIn.regdst     = regdstD;
    dIn.jump       = jumpD;
    dIn.multstart  = multstartD;
    dIn.multsgn    = multsgnD;
    dIn.wbsrc      = wbsrcD;
    dIn.alucontrol = alucontrolD;
    dIn.alusrc     = alusrcD;
    dIn.rd1        = rd1D;
    dIn.rd2        = rd2D;
    dIn.signimm    = signimmD;
    dIn.unsignimm  = unsignimmD;
    dIn.pcplus4    = pcplus4D;
    dIn.rs         = rsD;
    dIn.rt         = rtD;
    dIn.re         = reD;
  end

  // flushE wins over stallE so a stalled bubble really becomes a nop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        e <= '0;
    else if (flushE)  e <= '0;
    else if (!stallE) e <= dIn;
  end

  logic [WIDTH-1:0] srcA, srcB, fwdB, aluRes;

  always_comb begin
    case (forwardAE)
      2'b01:   srcA = resultW;
      2'b10:   srcA = aluoutM;
      default: srcA = e.rd1;
    endcase
    case (forwardBE)
      2'b01:   fwdB = resultW;
      2'b10:   fwdB = aluoutM;
      default: fwdB = e.rd2;
    endcase
    case (e.alusrc)
      2'b01:   srcB = e.signimm;
      2'b10:   srcB = e.unsignimm;
      default: srcB = fwdB;
    endcase
  end

  always_comb begin
    case (e.alucontrol)
      3'b000:  aluRes = srcA & srcB;
      3'b001:  aluRes = srcA | srcB;
      3'b010:  aluRes = srcA + srcB;
      3'b011:  aluRes = srcA ^ srcB;
      3'b100:  aluRes = ~(srcA ^ srcB);
      3'b101:  aluRes = srcA - srcB;
      3'b110:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      default: aluRes = srcB << 16;
    endcase
  end

  mulState_t          mulState;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, mcand, stepSum, product;
  logic [WIDTH-1:0]   mplier, magA, magB, hiReg, loReg, hiView, loView;
  logic               negRes, busyReg, lastStep;

  always_comb begin
    magA     = (e.multsgn && srcA[WIDTH-1]) ? -srcA : srcA;
    magB     = (e.multsgn && srcB[WIDTH-1]) ? -srcB : srcB;
    stepSum  = acc + (mplier[0] ? mcand : '0);
    product  = negRes ? -stepSum : stepSum;
    lastStep = (mulState == RUN) && (cnt == CW'(MUL_CYC - 1));
    // The finishing product is bypassed so the final busy cycle already sees it.
    hiView   = lastStep ? product[2*WIDTH-1:WIDTH] : hiReg;
    loView   = lastStep ? product[WIDTH-1:0]       : loReg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mulState <= IDLE;
      busyReg  <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      negRes   <= 1'b0;
      hiReg    <= '0;
      loReg    <= '0;
    end else begin
      case (mulState)
        IDLE: if (e.multstart && !busyReg && !stallE) begin
          mcand    <= {{WIDTH{1'b0}}, magA};
          mplier   <= magB;
          acc      <= '0;
          negRes   <= e.multsgn & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
          cnt      <= '0;
          busyReg  <= 1'b1;
          mulState <= RUN;
        end
        RUN: begin
          acc    <= stepSum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (lastStep) begin
            {hiReg, loReg} <= product;
            busyReg        <= 1'b0;
            mulState       <= IDLE;
          end
        end
        default: mulState <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (e.wbsrc)
      WB_MFLO: aluoutE = loView;
      WB_MFHI: aluoutE = hiView;
      WB_JAL:  aluoutE = e.pcplus4;
      default: aluoutE = aluRes;
    endcase
  end

  assign regwriteE  = e.regwrite;
  assign memwriteE  = e.memwrite;
  assign wbsrcE     = e.wbsrc;
  assign rsE        = e.rs;
  assign rtE        = e.rt;
  assign writeregE  = e.jump ? 5'd31 : (e.regdst ? e.re : e.rt);
  assign writedataE = fwdB;
  assign hi         = hiReg;
  assign lo         = loReg;
  assign mult_busy  = busyReg;
  assign hilo_stall = busyReg & ((e.wbsrc == WB_MFLO) | (e.wbsrc == WB_MFHI) | e.multstart);

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU/forwarding vector table plus multiply, HI/LO hazard, flush/stall and reset sequences.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallE, flushE;
  logic        regwriteD, memwriteD, regdstD, jumpD, multstartD, multsgnD;
  logic [3:0]  wbsrcD;
  logic [2:0]  alucontrolD;
  logic [1:0]  alusrcD;
  logic [31:0] rd1D, rd2D, signimmD, unsignimmD, pcplus4D;
  logic [4:0]  rsD, rtD, reD;
  logic [1:0]  forwardAE, forwardBE;
  logic [31:0] resultW, aluoutM;
  logic        regwriteE, memwriteE;
  logic [3:0]  wbsrcE;
  logic [4:0]  rsE, rtE, writeregE;
  logic [31:0] aluoutE, writedataE, hi, lo;
  logic        mult_busy, hilo_stall;

  int checks   = 0;
  int failures = 0;

  execute_stage #(.WIDTH(32), .MUL_CYC(32)) dut (
    .clk(clk), .reset(reset), .stallE(stallE), .flushE(flushE),
    .regwriteD(regwriteD), .memwriteD(memwriteD), .regdstD(regdstD), .jumpD(jumpD),
    .multstartD(multstartD), .multsgnD(multsgnD), .wbsrcD(wbsrcD),
    .alucontrolD(alucontrolD), .alusrcD(alusrcD), .rd1D(rd1D), .rd2D(rd2D),
    .signimmD(signimmD), .unsignimmD(unsignimmD), .pcplus4D(pcplus4D),
    .rsD(rsD), .rtD(rtD), .reD(reD), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .resultW(resultW), .aluoutM(aluoutM), .regwriteE(regwriteE), .memwriteE(memwriteE),
    .wbsrcE(wbsrcE), .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .aluoutE(aluoutE),
    .writedataE(writedataE), .hi(hi), .lo(lo), .mult_busy(mult_busy), .hilo_stall(hilo_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        regdst, jump;
    logic [3:0]  wbsrc;
    logic [2:0]  aluctl;
    logic [1:0]  alusrc;
    logic [31:0] rd1, rd2, simm, uimm, pc4;
    logic [4:0]  rt, re;
    logic [1:0]  fwdA, fwdB;
    logic [31:0] resW, aluM;
    logic [31:0] expAlu;
    logic [4:0]  expWreg;
    logic [31:0] expWd;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic regdst, input logic jump, input logic [3:0] wbsrc,
                              input logic [2:0] aluctl, input logic [1:0] alusrc,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] simm, input logic [31:0] uimm, input logic [31:0] pc4,
                              input logic [4:0] rt, input logic [4:0] re,
                              input logic [1:0] fwdA, input logic [1:0] fwdB,
                              input logic [31:0] resW, input logic [31:0] aluM,
                              input logic [31:0] expAlu, input logic [4:0] expWreg,
                              input logic [31:0] expWd);
    vec_t v;
    v.regdst = regdst; v.jump = jump; v.wbsrc = wbsrc; v.aluctl = aluctl; v.alusrc = alusrc;
    v.rd1 = rd1; v.rd2 = rd2; v.simm = simm; v.uimm = uimm; v.pc4 = pc4;
    v.rt = rt; v.re = re; v.fwdA = fwdA; v.fwdB = fwdB; v.resW = resW; v.aluM = aluM;
    v.expAlu = expAlu; v.expWreg = expWreg; v.expWd = expWd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearD();
    regwriteD = 0; memwriteD = 0; regdstD = 0; jumpD = 0; multstartD = 0; multsgnD = 0;
    wbsrcD = 4'b0001; alucontrolD = 3'b010; alusrcD = 2'b00;
    rd1D = 0; rd2D = 0; signimmD = 0; unsignimmD = 0; pcplus4D = 0;
    rsD = 0; rtD = 0; reD = 0;
    forwardAE = 0; forwardBE = 0; resultW = 0; aluoutM = 0;
  endtask

  // Leaves the multiply sitting in E with the multiplier still idle.
  task automatic issueMult(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    clearD();
    multstartD = 1; multsgnD = sgn; rd1D = a; rd2D = b; wbsrcD = 4'b0010;
    tick();
    clearD();
  endtask

  task automatic runMult(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expHi, input logic [31:0] expLo);
    int busyCnt;
    issueMult(sgn, a, b);
    check({tag, "_idle_busy"}, {31'd0, mult_busy}, 32'd0);
    busyCnt = 0;
    tick();
    while (mult_busy && busyCnt < 100) begin
      busyCnt++;
      tick();
    end
    check({tag, "_busy_cycles"}, busyCnt, 32'd32);
    check({tag, "_hi"}, hi, expHi);
    check({tag, "_lo"}, lo, expLo);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int stallCnt;
    logic [31:0] lastAlu;

    vecs[0]  = mk(1,0,4'b0001,3'b010,2'b00, 32'd7,32'd5,0,0,0, 5'd2,5'd3, 2'b10,2'b00, 0,32'd100, 32'd105,5'd3,32'd5);
    vecs[1]  = mk(0,0,4'b0001,3'b110,2'b00, 32'hFFFFFFFF,32'd1,0,0,0, 5'd4,5'd0, 2'b00,2'b00, 0,0, 32'd1,5'd4,32'd1);
    vecs[2]  = mk(0,0,4'b0001,3'b101,2'b00, 32'd0,32'd1,0,0,0, 5'd5,5'd0, 2'b00,2'b00, 0,0, 32'hFFFFFFFF,5'd5,32'd1);
    vecs[3]  = mk(0,0,4'b0001,3'b111,2'b10, 32'd0,32'd0,0,32'h1234,0, 5'd6,5'd0, 2'b00,2'b00, 0,0, 32'h12340000,5'd6,32'd0);
    vecs[4]  = mk(0,0,4'b0001,3'b000,2'b00, 32'hF0F0,32'hFF00,0,0,0, 5'd7,5'd0, 2'b00,2'b00, 0,0, 32'hF000,5'd7,32'hFF00);
    vecs[5]  = mk(0,0,4'b0001,3'b001,2'b00, 32'hF0F0,32'h0F00,0,0,0, 5'd8,5'd0, 2'b00,2'b00, 0,0, 32'hFFF0,5'd8,32'h0F00);
    vecs[6]  = mk(0,0,4'b0001,3'b011,2'b00, 32'hFFFF0000,32'h0F0F0F0F,0,0,0, 5'd9,5'd0, 2'b00,2'b00, 0,0, 32'hF0F00F0F,5'd9,32'h0F0F0F0F);
    vecs[7]  = mk(0,0,4'b0001,3'b100,2'b00, 32'hFFFF0000,32'h0F0F0F0F,0,0,0, 5'd10,5'd0, 2'b00,2'b00, 0,0, 32'h0F0FF0F0,5'd10,32'h0F0F0F0F);
    vecs[8]  = mk(0,0,4'b0001,3'b010,2'b01, 32'd10,32'd99,32'hFFFFFFFE,0,0, 5'd11,5'd0, 2'b00,2'b00, 0,0, 32'd8,5'd11,32'd99);
    vecs[9]  = mk(0,1,4'b0000,3'b010,2'b00, 32'd1,32'd1,0,0,32'h400, 5'd2,5'd0, 2'b00,2'b00, 0,0, 32'h400,5'd31,32'd1);
    vecs[10] = mk(1,0,4'b0001,3'b101,2'b00, 32'd50,32'd77,0,0,0, 5'd1,5'd12, 2'b00,2'b01, 32'd8,0, 32'd42,5'd12,32'd8);
    vecs[11] = mk(0,0,4'b0001,3'b010,2'b11, 32'd3,32'd4,32'd100,32'd200,0, 5'd13,5'd0, 2'b00,2'b00, 0,0, 32'd7,5'd13,32'd4);
    vecs[12] = mk(0,0,4'b0001,3'b010,2'b00, 32'hFFFFFFFF,32'd2,0,0,0, 5'd14,5'd0, 2'b00,2'b00, 0,0, 32'd1,5'd14,32'd2);
    vecs[13] = mk(0,0,4'b0001,3'b110,2'b00, 32'h80000000,32'hFFFFFFFF,0,0,0, 5'd15,5'd0, 2'b01,2'b00, 32'd5,0, 32'd0,5'd15,32'hFFFFFFFF);

    reset = 1; stallE = 0; flushE = 0;
    clearD();
    tick();
    tick();
    check("rst_aluoutE", aluoutE, 0);
    check("rst_writeregE", {27'd0, writeregE}, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", {31'd0, mult_busy}, 0);
    check("rst_regwriteE", {31'd0, regwriteE}, 0);
    @(negedge clk);
    reset = 0;
    tick();

    for (int i = 0; i < 14; i++) begin
      clearD();
      regwriteD = 1; regdstD = vecs[i].regdst; jumpD = vecs[i].jump; wbsrcD = vecs[i].wbsrc;
      alucontrolD = vecs[i].aluctl; alusrcD = vecs[i].alusrc;
      rd1D = vecs[i].rd1; rd2D = vecs[i].rd2; signimmD = vecs[i].simm; unsignimmD = vecs[i].uimm;
      pcplus4D = vecs[i].pc4; rtD = vecs[i].rt; reD = vecs[i].re;
      forwardAE = vecs[i].fwdA; forwardBE = vecs[i].fwdB;
      resultW = vecs[i].resW; aluoutM = vecs[i].aluM;
      tick();
      check($sformatf("v%0d_aluoutE", i), aluoutE, vecs[i].expAlu);
      check($sformatf("v%0d_writeregE", i), {27'd0, writeregE}, {27'd0, vecs[i].expWreg});
      check($sformatf("v%0d_writedataE", i), writedataE, vecs[i].expWd);
    end

    runMult("mult", 1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    runMult("multu", 1'b0, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1);

    // mflo three cycles behind a mult; the bench plays the hazard unit.
    issueMult(1'b1, 32'd7, 32'd6);
    tick();
    tick();
    clearD();
    regwriteD = 1; regdstD = 1; reD = 5'd8; wbsrcD = 4'b1101;
    tick();
    check("mflo_stall_on_entry", {31'd0, hilo_stall}, 1);
    stallCnt = 0;
    lastAlu = 0;
    while (hilo_stall && stallCnt < 100) begin
      stallE = 1;
      lastAlu = aluoutE;
      stallCnt++;
      tick();
    end
    stallE = 0;
    check("mflo_stall_cycles", stallCnt, 30);
    check("mflo_stall_released", {31'd0, hilo_stall}, 0);
    check("mflo_bypass_last_cycle", lastAlu, 32'd42);
    check("mflo_aluoutE", aluoutE, 32'd42);
    check("mflo_writeregE", {27'd0, writeregE}, 32'd8);
    check("mflo_hi", hi, 0);

    clearD();
    regwriteD = 1; memwriteD = 1; wbsrcD = 4'b0101; rd1D = 7; rd2D = 5;
    tick();
    check("pre_flush_regwriteE", {31'd0, regwriteE}, 1);
    check("pre_flush_aluoutE", aluoutE, 32'd12);
    flushE = 1; stallE = 1;
    tick();
    check("flush_regwriteE", {31'd0, regwriteE}, 0);
    check("flush_memwriteE", {31'd0, memwriteE}, 0);
    check("flush_wbsrcE", {28'd0, wbsrcE}, 0);
    flushE = 0; stallE = 0;
    tick();
    regwriteD = 0; memwriteD = 0; wbsrcD = 4'b0111; rd1D = 100;
    stallE = 1;
    tick();
    check("stall_regwriteE", {31'd0, regwriteE}, 1);
    check("stall_memwriteE", {31'd0, memwriteE}, 1);
    check("stall_wbsrcE", {28'd0, wbsrcE}, 32'd5);
    check("stall_aluoutE", aluoutE, 32'd12);
    stallE = 0;

    issueMult(1'b1, 32'hFFFFFFFD, 32'd5);
    tick();
    for (int i = 1; i < 10; i++) tick();
    check("mid_mult_busy_before_rst", {31'd0, mult_busy}, 1);
    #1 reset = 1;
    #1;
    check("mid_rst_busy", {31'd0, mult_busy}, 0);
    check("mid_rst_hi", hi, 0);
    check("mid_rst_lo", lo, 0);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 40; i++) tick();
    check("post_rst_busy", {31'd0, mult_busy}, 0);
    check("post_rst_hi", hi, 0);
    check("post_rst_lo", lo, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
